// File: rtl/imem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : imem_pkg                                                     |
// | Shared instruction-memory geometry and the loader FSM state encoding.  |
// | Used by the loader, the processor and the instruction memory.          |
// | Optional feature macro: IMEM_LOADER_CHECKSUM_EN                        |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package imem_pkg;

   localparam int IMEM_ADDR_WIDTH = 6;
   localparam int IMEM_DATA_WIDTH = 16;

   // Loader FSM states. The checksum states only exist when the trailer
   // checksum is enabled.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RECV_HI = 3'd1,
      RECV_LO = 3'd2,
      WRITE   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      DONE    = 3'd4,
      CHK_HI  = 3'd5,
      CHK_LO  = 3'd6
`else
      DONE    = 3'd4
`endif
   } imem_state_e;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : imem_loader                                                  |
// | Assembles a byte stream (high byte first) into 16-bit instruction      |
// | words and writes them to consecutive instruction-memory addresses.     |
// | Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a 16-bit XOR      |
// | checksum trailer that is compared against the written words.           |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = IMEM_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] load_len,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  we,
   output logic                  en,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] di,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   imem_state_e           state;
   imem_state_e           state_nxt;
   logic [ADDR_WIDTH-1:0] len_lat;
   logic                  xfer;
   logic                  last_word;

   // byte_ready depends on state only, so a transfer is simply both high.
   assign xfer = byte_valid & byte_ready;

   // load_len = 0 wraps to all-ones here, which is the 2^ADDR_WIDTH-word case.
   assign last_word = (addr == (len_lat - ADDR_WIDTH'(1)));

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] chk_acc;
   logic [7:0]            chk_hi;
`else
   assign error = 1'b0;
`endif

   // State register; reset dominates every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and state-decoded strobes.
   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      we         = 1'b0;
      en         = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = RECV_HI;
            end
         end
         RECV_HI: begin
            byte_ready = 1'b1;
            if (xfer) begin
               state_nxt = RECV_LO;
            end
         end
         RECV_LO: begin
            byte_ready = 1'b1;
            if (xfer) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            we = 1'b1;
            en = 1'b1;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = CHK_HI;
`else
               state_nxt = DONE;
`endif
            end else begin
               state_nxt = RECV_HI;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK_HI: begin
            byte_ready = 1'b1;
            if (xfer) begin
               state_nxt = CHK_LO;
            end
         end
         CHK_LO: begin
            byte_ready = 1'b1;
            if (xfer) begin
               state_nxt = DONE;
            end
         end
`endif
         DONE: begin
            busy      = 1'b0;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: length latch, byte-pair assembly, address counter, checksum.
   always_ff @(posedge clk) begin
      if (reset) begin
         len_lat <= '0;
         addr    <= '0;
         di      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk_acc <= '0;
         chk_hi  <= '0;
         error   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  len_lat <= load_len;
                  addr    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  chk_acc <= '0;
                  error   <= 1'b0;
`endif
               end
            end
            RECV_HI: begin
               if (xfer) begin
                  di[DATA_WIDTH-1:DATA_WIDTH-8] <= byte_data;
               end
            end
            RECV_LO: begin
               if (xfer) begin
                  di[7:0] <= byte_data;
               end
            end
            WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_acc <= chk_acc ^ di;
`endif
               // The address stops on the last word so it never wraps.
               if (!last_word) begin
                  addr <= addr + ADDR_WIDTH'(1);
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK_HI: begin
               if (xfer) begin
                  chk_hi <= byte_data;
               end
            end
            CHK_LO: begin
               if (xfer) begin
                  error <= ({chk_hi, byte_data} != chk_acc);
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_imem_loader                                               |
// | Scoreboard bench for imem_loader: expected writes and done pulses are  |
// | queued by the stimulus, a monitor pops and compares them.              |
// | Optional feature macro: IMEM_LOADER_CHECKSUM_EN                        |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_imem_loader;

   localparam int AW = 6;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] load_len;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          we;
   logic          en;
   logic [AW-1:0] addr;
   logic [DW-1:0] di;
   logic          busy;
   logic          done;
   logic          error;

   imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .load_len   (load_len),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .we         (we),
      .en         (en),
      .addr       (addr),
      .di         (di),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int cyc = 0;
   // Cycle counter used to time the done pulse.
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] a;
      logic [15:0]   d;
   } wr_t;
   typedef struct {
      int   c;   // expected cycle, -1 = any
      logic e;   // expected error value
   } dn_t;

   wr_t exp_wr[$];
   dn_t exp_dn[$];
   int  checks   = 0;
   int  passes   = 0;
   int  done_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic unexpected(input string nm, input logic [31:0] act);
      checks++;
      $display("FAIL %s: got event with value %0h expected no event", nm, act);
   endtask

   // Monitor: compares every write strobe and done pulse against the queues.
   always @(negedge clk) begin
      wr_t w;
      dn_t d;
      if (we) begin
         if (exp_wr.size() == 0) begin
            unexpected("write_unexpected", {10'd0, addr, di});
         end else begin
            w = exp_wr.pop_front();
            chk("write_addr", addr, w.a);
            chk("write_data", di, w.d);
            chk("write_en", en, 1'b1);
            chk("write_byte_ready", byte_ready, 1'b0);
            chk("write_busy", busy, 1'b1);
         end
      end else if (en) begin
         chk("en_without_we", en, 1'b0);
      end
      if (done) begin
         done_cnt++;
         if (exp_dn.size() == 0) begin
            unexpected("done_unexpected", cyc);
         end else begin
            d = exp_dn.pop_front();
            if (d.c >= 0) chk("done_cycle", cyc, d.c);
            chk("done_error", error, d.e);
            chk("done_busy", busy, 1'b0);
            chk("done_byte_ready", byte_ready, 1'b0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one byte and hold it until a cycle with byte_ready high.
   task automatic send_byte(input logic [7:0] b);
      logic rdy;
      rdy        = 1'b0;
      byte_valid = 1'b1;
      byte_data  = b;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         rdy = byte_ready;
         tick();
         if (rdy) break;
      end
      chk("byte_accept", rdy, 1'b1);
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic do_start(input logic [AW-1:0] len, output int st);
      load_len = len;
      start    = 1'b1;
      st       = cyc;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int k = 0; k < 500; k++) begin
         if (done_cnt >= target) break;
         tick();
      end
      chk("done_seen", done_cnt, target);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_we"}, we, 1'b0);
      chk({tag, "_en"}, en, 1'b0);
      chk({tag, "_byte_ready"}, byte_ready, 1'b0);
      chk({tag, "_addr"}, addr, '0);
      chk({tag, "_di"}, di, '0);
      chk({tag, "_error"}, error, 1'b0);
   endtask

   initial begin
      int st;
      reset      = 1'b1;
      start      = 1'b0;
      load_len   = '0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) tick();
      // Reset must dominate a simultaneous start.
      start    = 1'b1;
      load_len = 6'd2;
      tick();
      start    = 1'b0;
      chk_reset_outputs("reset");
      reset = 1'b0;
      tick();

      // Two words back-to-back, byte_valid held through WRITE and DONE.
      exp_wr.push_back('{6'd0, 16'h1234});
      exp_wr.push_back('{6'd1, 16'hABCD});
      do_start(6'd2, st);
      exp_dn.push_back('{st + 7, 1'b0});
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'hAB);
      send_byte(8'hCD);
      byte_data = 8'hEE;
      repeat (3) tick();
      byte_valid = 1'b0;
      wait_done(1);
      chk("idle_after_done_busy", busy, 1'b0);

      // Full memory (load_len = 0) with random gaps between bytes.
      for (int i = 0; i < 64; i++)
         exp_wr.push_back('{6'(i), {8'(i), 8'(i) ^ 8'h5A}});
      exp_dn.push_back('{-1, 1'b0});
      do_start(6'd0, st);
      for (int i = 0; i < 64; i++) begin
         byte_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         send_byte(8'(i));
         byte_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         send_byte(8'(i) ^ 8'h5A);
      end
      byte_valid = 1'b0;
      wait_done(2);
      chk("full_load_final_addr", addr, 6'd63);

      // Start pulses while busy must be ignored.
      exp_wr.push_back('{6'd0, 16'hC001});
      exp_wr.push_back('{6'd1, 16'hC102});
      exp_wr.push_back('{6'd2, 16'hC203});
      exp_dn.push_back('{-1, 1'b0});
      do_start(6'd3, st);
      send_word(16'hC001);
      byte_valid = 1'b0;
      load_len   = 6'd1;
      start      = 1'b1;
      repeat (2) tick();
      start = 1'b0;
      chk("busy_during_ignored_start", busy, 1'b1);
      send_word(16'hC102);
      send_word(16'hC203);
      byte_valid = 1'b0;
      wait_done(3);

      // Reset during RECV_LO of word 3 aborts the load.
      exp_wr.push_back('{6'd0, 16'h0100});
      exp_wr.push_back('{6'd1, 16'h0211});
      exp_wr.push_back('{6'd2, 16'h0322});
      do_start(6'd8, st);
      send_word(16'h0100);
      send_word(16'h0211);
      send_word(16'h0322);
      send_byte(8'h04);
      chk("abort_in_recv_lo_ready", byte_ready, 1'b1);
      byte_data = 8'h33;
      reset     = 1'b1;
      tick();
      chk_reset_outputs("abort");
      reset      = 1'b0;
      byte_valid = 1'b0;
      repeat (3) tick();
      chk("abort_no_done", done_cnt, 3);
      exp_wr.push_back('{6'd0, 16'h5AA5});
      exp_dn.push_back('{-1, 1'b0});
      do_start(6'd1, st);
      send_word(16'h5AA5);
      byte_valid = 1'b0;
      wait_done(4);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Matching checksum.
      exp_wr.push_back('{6'd0, 16'h1234});
      exp_wr.push_back('{6'd1, 16'hABCD});
      exp_dn.push_back('{-1, 1'b0});
      do_start(6'd2, st);
      send_word(16'h1234);
      send_word(16'hABCD);
      send_word(16'hB9F9);
      byte_valid = 1'b0;
      wait_done(5);
      // Wrong checksum: error latches and holds until the next start.
      exp_wr.push_back('{6'd0, 16'h1234});
      exp_wr.push_back('{6'd1, 16'hABCD});
      exp_dn.push_back('{-1, 1'b1});
      do_start(6'd2, st);
      send_word(16'h1234);
      send_word(16'hABCD);
      send_word(16'h0000);
      byte_valid = 1'b0;
      wait_done(6);
      repeat (3) tick();
      chk("error_held", error, 1'b1);
      exp_wr.push_back('{6'd0, 16'h0F0F});
      exp_dn.push_back('{-1, 1'b0});
      do_start(6'd1, st);
      chk("error_cleared_by_start", error, 1'b0);
      send_word(16'h0F0F);
      send_word(16'h0F0F);
      byte_valid = 1'b0;
      wait_done(7);
`endif

      repeat (5) tick();
      chk("write_queue_drained", exp_wr.size(), 0);
      chk("done_queue_drained", exp_dn.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_imem_loader
`default_nettype wire
